// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
//
// Upstream feeder for the single-cycle cpu. It consumes a byte stream of the
// form { N[15:8], N[7:0], 4*N image bytes (big-endian words) }. It assembles
// each group of four bytes into a 32-bit instruction and writes it into the
// cpu's instruction memory through a one-cycle initialize strobe. The cpu is
// held in reset until a complete image has been written.
//
// Parameters:
//   BASE_ADDR - byte address of the first instruction word
//   MAX_WORDS - largest accepted word count; a larger header is an error
//
// Ports:
//   clk                            in   system clock, rising edge
//   rst                            in   asynchronous active-high reset
//   load_start                     in   one-cycle load request (IDLE/DONE/ERR)
//   byte_valid                     in   byte_data is valid this cycle
//   byte_data[7:0]                 in   stream byte
//   byte_ready                     out  byte accepted when valid & ready
//   initialize                     out  instruction-memory write strobe
//   instruction_initialize_data    out  assembled instruction word
//   instruction_initialize_address out  byte address of that word
//   cpu_rst                        out  reset to the cpu (combinational)
//   done                           out  image loaded successfully (level)
//   error                          out  header exceeded MAX_WORDS (level)
// ---------------------------------------------------------------------------
module program_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        initialize,
    output logic [31:0] instruction_initialize_data,
    output logic [31:0] instruction_initialize_address,
    output logic        cpu_rst,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [15:0] MAX_WORDS_W = 16'(MAX_WORDS);

    state_t      state_reg, state_next;
    logic [15:0] count_reg, count_next;      // header word count N
    logic [15:0] words_reg, words_next;      // words written so far
    logic [1:0]  idx_reg, idx_next;          // byte position within a word
    logic [31:0] word_reg, word_next;        // shift register for assembly
    logic        init_reg, init_next;
    logic [31:0] data_reg, data_next;
    logic [31:0] addr_reg, addr_next;
    logic        ready_reg, ready_next;
    logic        done_reg, done_next;
    logic        error_reg, error_next;

    logic        xfer;
    logic [15:0] len_full;
    logic [15:0] words_inc;
    logic [31:0] word_shifted;

    assign xfer         = byte_valid & ready_reg;
    assign len_full     = {count_reg[15:8], byte_data};
    assign words_inc    = words_reg + 16'd1;
    assign word_shifted = {word_reg[23:0], byte_data};

    // -----------------------------------------------------------------------
    // Next-state and registered-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        words_next = words_reg;
        idx_next   = idx_reg;
        word_next  = word_reg;
        init_next  = 1'b0;
        data_next  = data_reg;
        addr_next  = addr_reg;

        case (state_reg)
            S_IDLE: begin
                if (load_start) begin
                    state_next = S_LEN_HI;
                end
            end

            S_LEN_HI: begin
                if (xfer) begin
                    count_next[15:8] = byte_data;
                    state_next       = S_LEN_LO;
                end
            end

            S_LEN_LO: begin
                if (xfer) begin
                    count_next = len_full;
                    if (len_full == 16'd0) begin
                        state_next = S_DONE;
                    end else if (len_full > MAX_WORDS_W) begin
                        state_next = S_ERR;
                    end else begin
                        state_next = S_DATA;
                        words_next = 16'd0;
                        idx_next   = 2'd0;
                    end
                end
            end

            S_DATA: begin
                if (xfer) begin
                    word_next = word_shifted;
                    idx_next  = idx_reg + 2'd1;
                    if (idx_reg == 2'd3) begin
                        // Strobe, data and address are registered on the
                        // same edge so they line up during the WRITE cycle.
                        state_next = S_WRITE;
                        init_next  = 1'b1;
                        data_next  = word_shifted;
                        addr_next  = BASE_ADDR + {14'd0, words_reg, 2'b00};
                    end
                end
            end

            S_WRITE: begin
                words_next = words_inc;
                if (words_inc == count_reg) begin
                    state_next = S_DONE;
                end else begin
                    state_next = S_DATA;
                end
            end

            S_DONE, S_ERR: begin
                if (load_start) begin
                    state_next = S_LEN_HI;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Level outputs follow the state being entered so they are valid
        // for the whole of that state while still coming from flops.
        ready_next = (state_next == S_LEN_HI) ||
                     (state_next == S_LEN_LO) ||
                     (state_next == S_DATA);
        done_next  = (state_next == S_DONE);
        error_next = (state_next == S_ERR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            count_reg <= 16'd0;
            words_reg <= 16'd0;
            idx_reg   <= 2'd0;
            word_reg  <= 32'd0;
            init_reg  <= 1'b0;
            data_reg  <= 32'd0;
            addr_reg  <= BASE_ADDR;
            ready_reg <= 1'b0;
            done_reg  <= 1'b0;
            error_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            words_reg <= words_next;
            idx_reg   <= idx_next;
            word_reg  <= word_next;
            init_reg  <= init_next;
            data_reg  <= data_next;
            addr_reg  <= addr_next;
            ready_reg <= ready_next;
            done_reg  <= done_next;
            error_reg <= error_next;
        end
    end

    assign byte_ready                     = ready_reg;
    assign initialize                     = init_reg;
    assign instruction_initialize_data    = data_reg;
    assign instruction_initialize_address = addr_reg;
    assign done                           = done_reg;
    assign error                          = error_reg;

    // Combinational so the cpu is held the instant reset asserts or a load
    // begins; it never runs a partial or absent image.
    assign cpu_rst = rst | (state_reg != S_DONE);

endmodule
